ls153_arbiter: RTL



---
 rtl/ls153_arb_pkg.sv | 20 ++
 rtl/ls153_arbiter_rr_pick4.sv | 33 +++
 rtl/ls153_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ls153_arb_pkg.sv
// Shared types and constants for the ls153 selector arbiter.
package ls153_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam int NREQ  = 4;
  localparam int IDXW  = 2;
  localparam int CNT_W = 8;

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDXW-1:0] idx);
    logic [NREQ-1:0] one_v;
    one_v = {{(NREQ-1){1'b0}}, 1'b1};
    return one_v << idx;
  endfunction

endpackage

// File: rtl/ls153_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request searching upward
// from the slot after the last owner, with wrap.
module rr_pick4
  import ls153_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic            valid,
  output logic [IDXW-1:0] w
);

  logic [IDXW-1:0]   start_s;
  logic [IDXW-1:0]   off_s;
  logic [2*NREQ-2:0] dbl_s;
  logic [NREQ-1:0]   rot_s;

  // Rotate requests so bit 0 is the highest-priority slot, then priority-encode.
  always_comb begin
    start_s = last + 2'd1;
    dbl_s   = {req[NREQ-2:0], req};
    rot_s   = dbl_s[3'(start_s) +: NREQ];
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
    valid = |req;
    w     = start_s + off_s;
  end

endmodule

// File: rtl/ls153_arbiter.sv
// Break-before-make round-robin owner of a shared 74LS153 selector.
// Optional owner preemption at MAX_HOLD is compiled in with LS153_ARB_TIMEOUT_EN.
module ls153_arbiter
  import ls153_arb_pkg::*;
#(
  parameter int MIN_HOLD  = 2,
  parameter int MAX_HOLD  = 16,
  parameter int GUARD_CYC = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            sel_a,
  output logic            sel_b,
  output logic            _stb,
  output logic            busy
);

`ifdef LS153_ARB_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HOLD_MIN_C = CNT_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_SAT_C = {CNT_W{1'b1}};
  localparam logic [3:0]       GUARD_C    = 4'(GUARD_CYC);

  state_t            state_r;
  logic [IDXW-1:0]   owner_r;
  logic [IDXW-1:0]   last_r;
  logic [CNT_W-1:0]  hold_r;
  logic [3:0]        guard_r;
  logic [NREQ-1:0]   gnt_r;
  logic              stb_r;
  logic              busy_r;

  logic              pick_valid_s;
  logic [IDXW-1:0]   pick_w_s;
  logic              own_req_s;
  logic              others_s;
  logic              timeout_s;
  logic              release_s;

  rr_pick4 u_pick (
    .req   (req),
    .last  (last_r),
    .valid (pick_valid_s),
    .w     (pick_w_s)
  );

  // Owner request status and the release decision for the GRANT state.
  always_comb begin
    own_req_s = req[owner_r];
    others_s  = |(req & ~idx_to_onehot(owner_r));
    timeout_s = TIMEOUT_EN && (hold_r >= HOLD_MAX_C) && others_s;
    release_s = ((hold_r >= HOLD_MIN_C) && !own_req_s) || timeout_s;
  end

  // Sequencer: select lines move only in IDLE, strobe drops only after the guard.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      owner_r <= 2'd0;
      last_r  <= 2'd3;
      hold_r  <= 8'd0;
      guard_r <= 4'd0;
      gnt_r   <= 4'd0;
      stb_r   <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            owner_r <= pick_w_s;
            guard_r <= 4'd1;
            busy_r  <= 1'b1;
            state_r <= GUARD;
          end
        end
        GUARD: begin
          if (!own_req_s) begin
            guard_r <= 4'd0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (guard_r >= GUARD_C) begin
            guard_r <= 4'd0;
            gnt_r   <= idx_to_onehot(owner_r);
            stb_r   <= 1'b0;
            hold_r  <= 8'd1;
            state_r <= GRANT;
          end else begin
            guard_r <= guard_r + 4'd1;
          end
        end
        GRANT: begin
          if (release_s) begin
            gnt_r   <= 4'd0;
            stb_r   <= 1'b1;
            busy_r  <= 1'b0;
            hold_r  <= 8'd0;
            last_r  <= owner_r;
            state_r <= IDLE;
          end else if (hold_r != HOLD_SAT_C) begin
            hold_r <= hold_r + 8'd1;
          end
        end
        default: begin
          gnt_r   <= 4'd0;
          stb_r   <= 1'b1;
          busy_r  <= 1'b0;
          hold_r  <= 8'd0;
          guard_r <= 4'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign gnt   = gnt_r;
  assign sel_a = owner_r[0];
  assign sel_b = owner_r[1];
  assign _stb  = stb_r;
  assign busy  = busy_r;

endmodule
